// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture
//   Receiving end of the whizgraphics pixel stream. 2-bit shade pixels arrive
//   in raster order and are packed four per byte (first pixel in the LSBs)
//   into an internal framebuffer. Line/frame geometry is validated. When a
//   full frame is held, frame_done is raised and the pixel stream is
//   backpressured until the host releases the frame with frame_ack.
//
// Optional feature (macro LCD_CAPTURE_CRC_EN):
//   adds frame_crc, a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over every
//   packed byte written, MSB first, restarted on each SOF transfer.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   capture_req        pulse: arm capture of the next frame
//   pix_valid/ready    pixel handshake; transfer when both high
//   pix_data           2-bit shade, 0 = lightest
//   pix_sof/pix_eol    first pixel of frame / last pixel of line
//   rd_addr/rd_data    framebuffer byte read port, 1-cycle latency
//   frame_done         level: complete frame held
//   frame_ack          pulse: host finished with the frame
//   line_err           sticky geometry error, cleared on capture_req
//   busy               waiting for SOF or capturing
//   frame_crc          (LCD_CAPTURE_CRC_EN only) running frame CRC
module lcd_frame_capture #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [1:0]        pix_data,
  input  logic              pix_sof,
  input  logic              pix_eol,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic              line_err,
  output logic              busy
`ifdef LCD_CAPTURE_CRC_EN
  ,
  output logic [15:0]       frame_crc
`endif
);

  localparam int unsigned DEPTH  = WIDTH * HEIGHT / 4;
  localparam int unsigned COL_W  = $clog2(WIDTH);
  localparam int unsigned LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WIDTH / 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DONE} state_t;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [LINE_W-1:0]   line;
  logic [ADDR_W-1:0]   line_base;
  logic [5:0]          pack;        // first three pixels of the current byte
  logic [7:0]          mem [DEPTH];

  logic                xfer;
  logic                start;
  logic                eol_early;
  logic                line_end;
  logic                wr_en;
  logic [7:0]          wr_byte;
  logic [ADDR_W-1:0]   wr_addr;

  // Since WIDTH is a multiple of 4, the position within a byte is col[1:0]
  // and the byte address is the line base plus col/4.
  always_comb begin
    xfer      = pix_valid && pix_ready;
    start     = xfer && pix_sof && ((state == S_WAIT_SOF) || (state == S_CAPTURE));
    eol_early = pix_eol && (col != COL_LAST);
    line_end  = pix_eol || (col == COL_LAST);
    wr_byte   = {pix_data, pack};
    wr_addr   = line_base + ADDR_W'(col[COL_W-1:2]);
    wr_en     = (state == S_CAPTURE) && xfer && !pix_sof && !eol_early &&
                (col[1:0] == 2'd3);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      col        <= '0;
      line       <= '0;
      line_base  <= '0;
      pack       <= '0;
      pix_ready  <= 1'b1;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture_req) begin
            state    <= S_WAIT_SOF;
            busy     <= 1'b1;
            line_err <= 1'b0;
          end
        end
        S_WAIT_SOF: begin
          if (start) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (start) begin
            line_err <= 1'b1;
          end else if (xfer) begin
            if (line_end) begin
              // Early EOL and missing EOL both end the line; an early EOL
              // drops the partial byte because wr_en is suppressed.
              if (pix_eol != (col == COL_LAST)) line_err <= 1'b1;
              col <= '0;
              if (line == LINE_LAST) begin
                state      <= S_DONE;
                frame_done <= 1'b1;
                pix_ready  <= 1'b0;
                busy       <= 1'b0;
              end else begin
                line      <= line + LINE_W'(1);
                line_base <= line_base + LINE_BYTES;
              end
            end else begin
              col <= col + COL_W'(1);
              case (col[1:0])
                2'd0:    pack[1:0] <= pix_data;
                2'd1:    pack[3:2] <= pix_data;
                2'd2:    pack[5:4] <= pix_data;
                default: ;
              endcase
            end
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
            pix_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // SOF pixel (first or restarting) is stored as index 0.
      if (start) begin
        col       <= COL_W'(1);
        line      <= '0;
        line_base <= '0;
        pack[1:0] <= pix_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  rd_data <= '0;
    else if (32'(rd_addr) < DEPTH) rd_data <= mem[rd_addr];
    else                           rd_data <= '0;
  end

`ifdef LCD_CAPTURE_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  d;
    r = c;
    d = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ d[7]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
      d = {d[6:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   frame_crc <= 16'hFFFF;
    else if (start) frame_crc <= 16'hFFFF;
    else if (wr_en) frame_crc <= crc16_byte(frame_crc, wr_byte);
  end
`endif

endmodule

// File: tb/tb_lcd_frame_capture.sv
module tb_lcd_frame_capture;

  localparam int W    = 160;
  localparam int H    = 36;
  localparam int AW   = 11;
  localparam int NPIX = W * H;
  localparam int NB   = NPIX / 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          capture_req = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_eol = 1'b0;
  logic          frame_ack = 1'b0;
  logic [1:0]    pix_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          pix_ready, frame_done, line_err, busy;
  logic [7:0]    rd_data;
`ifdef LCD_CAPTURE_CRC_EN
  logic [15:0]   frame_crc;
`endif

  int checks = 0;
  int errors = 0;
  bit gaps = 1'b0;
  int px [NPIX];
  logic [7:0] exp_mem [NB];

  lcd_frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .frame_ack(frame_ack), .line_err(line_err),
    .busy(busy)
`ifdef LCD_CAPTURE_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One pixel transfer, optionally preceded by idle cycles carrying junk.
  task automatic xfer(input logic [1:0] d, input logic sof, input logic eol);
    while (gaps && $urandom_range(3) == 0) begin
      pix_valid = 1'b0;
      pix_data  = 2'($urandom);
      pix_sof   = 1'($urandom);
      pix_eol   = 1'($urandom);
      tick;
    end
    pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eol = eol;
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL pix_ready_xfer: got %b want 1", pix_ready);
    end
    tick;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
  endtask

  // kind: 0 = n%4, 1 = all 3, 2 = random, 3 = all 0
  task automatic make_frame(input int kind);
    for (int n = 0; n < NPIX; n++) begin
      case (kind)
        0:       px[n] = n % 4;
        1:       px[n] = 3;
        2:       px[n] = int'($urandom_range(3));
        default: px[n] = 0;
      endcase
    end
    for (int k = 0; k < NB; k++)
      exp_mem[k] = 8'(px[4*k] + px[4*k+1]*4 + px[4*k+2]*16 + px[4*k+3]*64);
  endtask

  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < NB; k++)
      for (int b = 7; b >= 0; b--)
        c = (c[15] ^ exp_mem[k][b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic check_done_state(input string tag);
    checks++;
    if (frame_done !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done/ready/busy=%b%b%b want 100", tag, frame_done, pix_ready, busy);
    end
  endtask

  // Clean frame from px[]: SOF on pixel 0, EOL on the last column.
  task automatic send_frame(input string tag);
    for (int n = 0; n < NPIX; n++) begin
      if (n == NPIX - 1) begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL %s_early_done: got %b want 0", tag, frame_done);
        end
      end
      xfer(2'(px[n]), n == 0, (n % W) == W - 1);
    end
    check_done_state(tag);
  endtask

  task automatic check_mem(input string tag, input int skip_lo, input int skip_hi);
    logic [7:0] prev;
    bit have;
    have = 1'b0;
    prev = '0;
    for (int k = 0; k < NB; k++) begin
      if (k >= skip_lo && k <= skip_hi) continue;
      rd_addr = AW'(k);
      if (have) begin
        #1;
        checks++;
        if (rd_data !== prev) begin
          errors++; $display("FAIL %s_rd_latency addr %0d: got %h want %h", tag, k, rd_data, prev);
        end
      end
      tick;
      checks++;
      if (rd_data !== exp_mem[k]) begin
        errors++; $display("FAIL %s_byte addr %0d: got %h want %h", tag, k, rd_data, exp_mem[k]);
      end
      prev = exp_mem[k];
      have = 1'b1;
    end
    rd_addr = AW'(NB);
    tick;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL %s_rd_oob addr %0d: got %h want 00", tag, NB, rd_data);
    end
    rd_addr = '1;
    tick;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL %s_rd_oob_top: got %h want 00", tag, rd_data);
    end
  endtask

  task automatic pulse_capture(input string tag);
    capture_req = 1'b1; tick; capture_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || line_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_arm: busy/line_err/done=%b%b%b want 100", tag, busy, line_err, frame_done);
    end
  endtask

  task automatic pulse_ack(input string tag);
    frame_ack = 1'b1; tick; frame_ack = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: done/ready/busy=%b%b%b want 010", tag, frame_done, pix_ready, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) begin
      capture_req = 1'($urandom); pix_valid = 1'($urandom); tick;
    end
    capture_req = 1'b0; pix_valid = 1'b0;
    checks++;
    if (pix_ready !== 1'b1 || frame_done !== 1'b0 || line_err !== 1'b0 ||
        busy !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: ready/done/err/busy=%b%b%b%b rd=%h want 1000 00",
               pix_ready, frame_done, line_err, busy, rd_data);
    end
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) xfer(2'($urandom), 1'($urandom), 1'($urandom));
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_stream: done/busy=%b%b want 00", frame_done, busy);
    end
  endtask

  task automatic test_pattern_frame;
    pulse_capture("pattern");
    make_frame(0);
    send_frame("pattern");
    check_mem("pattern", -1, -1);
  endtask

  task automatic test_done_hold;
    capture_req = 1'b0;
    pix_valid = 1'b1; pix_data = 2'd0; pix_sof = 1'b1; pix_eol = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) capture_req = 1'b1;
      tick;
      capture_req = 1'b0;
      checks++;
      if (pix_ready !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: ready/done/busy=%b%b%b want 010", pix_ready, frame_done, busy);
      end
    end
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    check_mem("done_hold", -1, -1);
    pulse_ack("done_hold");
    frame_ack = 1'b1; tick; frame_ack = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_idle: done/busy/ready=%b%b%b want 001", frame_done, busy, pix_ready);
    end
  endtask

  task automatic test_armed_discard;
    pulse_capture("discard");
    for (int i = 0; i < 3; i++) xfer(2'd1, 1'b0, 1'($urandom));
    checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL wait_sof: busy/done=%b%b want 10", busy, frame_done);
    end
    make_frame(1);
    send_frame("all3");
    check_mem("all3", -1, -1);
    pulse_ack("all3");
  endtask

  task automatic test_random_gaps;
    pulse_capture("random");
    make_frame(2);
    gaps = 1'b1;
    send_frame("random");
    gaps = 1'b0;
    check_mem("random", -1, -1);
`ifdef LCD_CAPTURE_CRC_EN
    checks++;
    if (frame_crc !== model_crc()) begin
      errors++; $display("FAIL random_crc: got %h want %h", frame_crc, model_crc());
    end
`endif
    pulse_ack("random");
  endtask

  // EOL at column 99 of line 5: line ends early, bytes from col 96 on are not written.
  task automatic test_eol_early;
    pulse_capture("eol_early");
    make_frame(2);
    for (int l = 0; l < H; l++) begin
      for (int c = 0; c < W; c++) begin
        bit bad;
        bad = (l == 5 && c == 99);
        if (l == H - 1 && c == W - 1) begin
          checks++;
          if (frame_done !== 1'b0) begin
            errors++; $display("FAIL eol_early_done_early: got %b want 0", frame_done);
          end
        end
        xfer(2'(px[l*W + c]), l == 0 && c == 0, bad || c == W - 1);
        if (l == 5 && (c == 98 || c == 99)) begin
          checks++;
          if (line_err !== (c == 99)) begin
            errors++; $display("FAIL eol_early_err col %0d: got %b want %b", c, line_err, c == 99);
          end
        end
        if (bad) break;
      end
    end
    check_done_state("eol_early");
    check_mem("eol_early", 5*(W/4) + 24, 5*(W/4) + (W/4) - 1);
    pulse_ack("eol_early");
    checks++;
    if (line_err !== 1'b1) begin
      errors++; $display("FAIL line_err_sticky: got %b want 1", line_err);
    end
  endtask

  // Missing EOL on line 2: flagged, but the line still ends normally.
  task automatic test_eol_missing;
    pulse_capture("eol_missing");
    make_frame(2);
    for (int n = 0; n < NPIX; n++) begin
      bit miss;
      miss = (n == 2*W + W - 1);
      xfer(2'(px[n]), n == 0, ((n % W) == W - 1) && !miss);
      if (n == 2*W + W - 2 || miss) begin
        checks++;
        if (line_err !== miss) begin
          errors++; $display("FAIL eol_missing_err pix %0d: got %b want %b", n, line_err, miss);
        end
      end
    end
    check_done_state("eol_missing");
    check_mem("eol_missing", -1, -1);
    pulse_ack("eol_missing");
  endtask

  // SOF at pixel 500 restarts the frame; a full frame must follow it.
  task automatic test_sof_restart;
    pulse_capture("sof");
    make_frame(2);
    for (int n = 0; n < 500; n++) xfer(2'(px[n]), n == 0, (n % W) == W - 1);
    checks++;
    if (line_err !== 1'b0) begin
      errors++; $display("FAIL sof_pre_err: got %b want 0", line_err);
    end
    make_frame(2);
    send_frame("sof");
    checks++;
    if (line_err !== 1'b1) begin
      errors++; $display("FAIL sof_err: got %b want 1", line_err);
    end
    check_mem("sof", -1, -1);
    pulse_ack("sof");
  endtask

`ifdef LCD_CAPTURE_CRC_EN
  task automatic test_crc_zero;
    pulse_capture("crc0");
    make_frame(3);
    send_frame("crc0");
    repeat (4) tick;
    checks++;
    if (frame_crc !== model_crc()) begin
      errors++; $display("FAIL crc_zero: got %h want %h", frame_crc, model_crc());
    end
    pulse_ack("crc0");
  endtask
`endif

  task automatic test_reset_midframe;
    pulse_capture("midreset");
    make_frame(2);
    for (int n = 0; n < 100; n++) xfer(2'(px[n]), n == 0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b1 || line_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset: busy/done/ready/err=%b%b%b%b want 0010", busy, frame_done, pix_ready, line_err);
    end
    tick;
    reset_n = 1'b1;
    tick;
    for (int n = 0; n < 2*W; n++) xfer(2'($urandom), n == 0, (n % W) == W - 1);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: busy/done=%b%b want 00", busy, frame_done);
    end
  endtask

  initial begin
    test_reset;
    test_pattern_frame;
    test_done_hold;
    test_armed_discard;
    test_random_gaps;
    test_eol_early;
    test_eol_missing;
    test_sof_restart;
`ifdef LCD_CAPTURE_CRC_EN
    test_crc_zero;
`endif
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
